// File: rtl/gray_pkg.sv
// Shared definitions for Gray counter readers.
//   reader_state_t : capture FSM states (IDLE, CONV, PRESENT)
//   gray2bin       : reflected-Gray to binary conversion on a 32-bit container
//   multi_bit      : true when more than one bit of the argument is set
// Readers narrower than 32 bits zero-extend into these helpers and truncate
// the result, so W may be anything from 2 to GRAY_MAX_W.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PRESENT
  } reader_state_t;

  // Zero upper bits stay zero through the prefix XOR, so a zero-extended
  // narrow code converts correctly in its low bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_bit(input logic [GRAY_MAX_W-1:0] x);
    return (x & (x - GRAY_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-stage flop synchronizer for a W-bit Gray bus.
//   clk_master : destination clock
//   rstb       : asynchronous active-low reset, clears every stage
//   d          : Gray code from the source domain
//   q          : synchronized Gray code, STAGES cycles behind d
// Bit-wise synchronizing is safe only because at most one bit of a Gray
// count changes per source step.
module gray_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_master,
  input  logic         rstb,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_count_reader.sv
// Reader end of the Gray counter tree.
// Synchronizes the free-running Gray count, captures it on sample_req,
// converts the capture to binary and reports the modulo-2^W delta since the
// previous capture over a valid/ready handshake. Sticky flags report illegal
// multi-bit Gray steps and requests that arrive while a result is in flight.
//   clk_master, rstb       : clock and asynchronous active-low reset
//   gray_in                : Gray count, asynchronous to clk_master
//   sample_req             : one-cycle capture request
//   dout_ready             : consumer takes the presented result
//   err_clr                : clears gray_err and overrun (a same-cycle set wins)
//   bin_out, delta_out     : captured binary value and delta to previous capture
//   dout_valid             : bin_out/delta_out are presented
//   gray_err, overrun      : sticky error flags
module gray_count_reader
  import gray_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_master,
  input  logic         rstb,
  input  logic [W-1:0] gray_in,
  input  logic         sample_req,
  input  logic         dout_ready,
  input  logic         err_clr,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] delta_out,
  output logic         dout_valid,
  output logic         gray_err,
  output logic         overrun
);

  reader_state_t state, next_state;

  logic [W-1:0] sync_g;
  logic [W-1:0] prev_sync;
  logic [W-1:0] cap_gray;
  logic [W-1:0] last_bin;
  logic [W-1:0] conv_bin;

  logic load_cap;
  logic load_result;
  logic drop_valid;
  logic req_dropped;
  logic step_bad;

  gray_sync #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_master (clk_master),
    .rstb       (rstb),
    .d          (gray_in),
    .q          (sync_g)
  );

  assign conv_bin = W'(gray2bin(GRAY_MAX_W'(cap_gray)));
  assign step_bad = multi_bit(GRAY_MAX_W'(sync_g ^ prev_sync));

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A request is honoured only in IDLE or when the presented result is being
  // accepted in the same cycle; anywhere else it is dropped and flagged.
  always_comb begin
    next_state  = state;
    load_cap    = 1'b0;
    load_result = 1'b0;
    drop_valid  = 1'b0;
    req_dropped = 1'b0;
    case (state)
      IDLE: begin
        if (sample_req) begin
          load_cap   = 1'b1;
          next_state = CONV;
        end
      end
      CONV: begin
        load_result = 1'b1;
        req_dropped = sample_req;
        next_state  = PRESENT;
      end
      PRESENT: begin
        if (dout_ready) begin
          drop_valid = 1'b1;
          if (sample_req) begin
            load_cap   = 1'b1;
            next_state = CONV;
          end else begin
            next_state = IDLE;
          end
        end else begin
          req_dropped = sample_req;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      prev_sync  <= '0;
      cap_gray   <= '0;
      last_bin   <= '0;
      bin_out    <= '0;
      delta_out  <= '0;
      dout_valid <= 1'b0;
    end else begin
      prev_sync <= sync_g;
      if (load_cap) begin
        cap_gray <= sync_g;
      end
      if (load_result) begin
        bin_out    <= conv_bin;
        delta_out  <= conv_bin - last_bin;
        last_bin   <= conv_bin;
        dout_valid <= 1'b1;
      end else if (drop_valid) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // Set has priority over err_clr so an event in the clearing cycle is kept.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      gray_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (step_bad) begin
        gray_err <= 1'b1;
      end else if (err_clr) begin
        gray_err <= 1'b0;
      end
      if (req_dropped) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_count_reader.sv
// Self-checking bench for gray_count_reader at W=4, SYNC_STAGES=2.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_gray_count_reader;

  localparam int TW = 4;
  localparam int TS = 2;

  logic          clk_master = 1'b0;
  logic          rstb = 1'b1;
  logic [TW-1:0] gray_in = '0;
  logic          sample_req = 1'b0;
  logic          dout_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [TW-1:0] bin_out;
  logic [TW-1:0] delta_out;
  logic          dout_valid;
  logic          gray_err;
  logic          overrun;

  int compared = 0;
  int mismatched = 0;

  logic [TW-1:0] cur = '0;
  logic [TW-1:0] model_last = '0;
  logic [TW-1:0] hist [$];

  typedef struct {
    logic [TW-1:0] gray;
    logic [TW-1:0] exp_bin;
    logic [TW-1:0] exp_delta;
  } vec_t;

  vec_t vecs [6];

  gray_count_reader #(
    .W           (TW),
    .SYNC_STAGES (TS)
  ) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .gray_in    (gray_in),
    .sample_req (sample_req),
    .dout_ready (dout_ready),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .delta_out  (delta_out),
    .dout_valid (dout_valid),
    .gray_err   (gray_err),
    .overrun    (overrun)
  );

  always #5 clk_master = ~clk_master;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Standard reflected Gray code of a binary count.
  function automatic logic [TW-1:0] to_gray(input logic [TW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits for the next falling edge, then drives the count (optionally one
  // step on) and records it so captures can be predicted from history.
  task automatic set_bin(input logic [TW-1:0] v);
    @(negedge clk_master);
    cur = v;
    gray_in = to_gray(cur);
    hist.push_back(cur);
  endtask

  task automatic apply_stimulus(input bit adv);
    set_bin(adv ? cur + 1'b1 : cur);
  endtask

  task automatic walk_to_gray(input logic [TW-1:0] target);
    for (int i = 0; i < 16 && gray_in != target; i++) begin
      apply_stimulus(1'b1);
    end
    check_output("walk_reached", int'(gray_in), int'(target));
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
  endtask

  task automatic do_capture(input string name, input logic [TW-1:0] eb, input logic [TW-1:0] ed);
    apply_stimulus(1'b0);
    sample_req = 1'b1;
    apply_stimulus(1'b0);
    sample_req = 1'b0;
    apply_stimulus(1'b0);
    check_output({name, "_valid"}, int'(dout_valid), 1);
    check_output({name, "_bin"}, int'(bin_out), int'(eb));
    check_output({name, "_delta"}, int'(delta_out), int'(ed));
    model_last = eb;
  endtask

  task automatic release_result(input string name);
    dout_ready = 1'b1;
    apply_stimulus(1'b0);
    dout_ready = 1'b0;
    check_output({name, "_valid_drop"}, int'(dout_valid), 0);
  endtask

  initial begin
    logic [TW-1:0] exp_bin;
    logic [TW-1:0] exp_delta;
    bit            pending;
    bit            b2b;

    vecs[0] = '{gray: 4'b1001, exp_bin: 4'd14, exp_delta: 4'd9};
    vecs[1] = '{gray: 4'b0011, exp_bin: 4'd2,  exp_delta: 4'd4};
    vecs[2] = '{gray: 4'b0011, exp_bin: 4'd2,  exp_delta: 4'd0};
    vecs[3] = '{gray: 4'b0010, exp_bin: 4'd3,  exp_delta: 4'd1};
    vecs[4] = '{gray: 4'b1000, exp_bin: 4'd15, exp_delta: 4'd12};
    vecs[5] = '{gray: 4'b0000, exp_bin: 4'd0,  exp_delta: 4'd1};

    for (int i = 0; i < 3; i++) hist.push_back('0);

    // Reset state
    #1 rstb = 1'b0;
    #1;
    check_output("rst_valid", int'(dout_valid), 0);
    check_output("rst_bin", int'(bin_out), 0);
    check_output("rst_delta", int'(delta_out), 0);
    check_output("rst_gray_err", int'(gray_err), 0);
    check_output("rst_overrun", int'(overrun), 0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    rstb = 1'b1;

    // First capture: delta equals value
    walk_to_gray(4'b0111);
    do_capture("first", 4'd5, 4'd5);
    check_output("first_gray_err", int'(gray_err), 0);
    check_output("first_overrun", int'(overrun), 0);

    // Held result while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0);
      check_output("hold_valid", int'(dout_valid), 1);
      check_output("hold_bin", int'(bin_out), 5);
      check_output("hold_delta", int'(delta_out), 5);
    end
    release_result("hold");

    // Table of captures along a legal Gray walk, including wrap and equal values
    for (int i = 0; i < 6; i++) begin
      walk_to_gray(vecs[i].gray);
      do_capture($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_delta);
      check_output($sformatf("vec%0d_gray_err", i), int'(gray_err), 0);
      release_result($sformatf("vec%0d", i));
    end

    // Illegal two-bit step, detection latency, clear, and set-over-clear
    set_bin(4'd2);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    check_output("gerr_early", int'(gray_err), 0);
    apply_stimulus(1'b0);
    check_output("gerr_set", int'(gray_err), 1);
    err_clr = 1'b1;
    apply_stimulus(1'b0);
    err_clr = 1'b0;
    check_output("gerr_cleared", int'(gray_err), 0);
    err_clr = 1'b1;
    set_bin(4'd0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    check_output("gerr_clr_quiet", int'(gray_err), 0);
    apply_stimulus(1'b0);
    check_output("gerr_set_wins", int'(gray_err), 1);
    apply_stimulus(1'b0);
    check_output("gerr_clr_after", int'(gray_err), 0);
    err_clr = 1'b0;
    apply_stimulus(1'b0);

    // Overrun in CONV and in stalled PRESENT, then back-to-back capture
    apply_stimulus(1'b0);
    sample_req = 1'b1;
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    sample_req = 1'b0;
    check_output("ovr_conv_flag", int'(overrun), 1);
    check_output("ovr_conv_valid", int'(dout_valid), 1);
    check_output("ovr_conv_bin", int'(bin_out), 0);
    check_output("ovr_conv_delta", int'(delta_out), 0);
    model_last = 4'd0;
    err_clr = 1'b1;
    apply_stimulus(1'b0);
    err_clr = 1'b0;
    check_output("ovr_cleared", int'(overrun), 0);
    sample_req = 1'b1;
    apply_stimulus(1'b0);
    sample_req = 1'b0;
    check_output("ovr_present_flag", int'(overrun), 1);
    check_output("ovr_present_valid", int'(dout_valid), 1);
    check_output("ovr_present_bin", int'(bin_out), 0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    err_clr = 1'b1;
    apply_stimulus(1'b0);
    err_clr = 1'b0;
    sample_req = 1'b1;
    dout_ready = 1'b1;
    apply_stimulus(1'b0);
    sample_req = 1'b0;
    dout_ready = 1'b0;
    check_output("b2b_gap_valid", int'(dout_valid), 0);
    apply_stimulus(1'b0);
    check_output("b2b_valid", int'(dout_valid), 1);
    check_output("b2b_bin", int'(bin_out), 1);
    check_output("b2b_delta", int'(delta_out), 1);
    check_output("b2b_overrun", int'(overrun), 0);
    model_last = 4'd1;
    release_result("b2b");

    // Asynchronous reset while a result is presented
    walk_to_gray(to_gray(4'd4));
    do_capture("pre_rst", 4'd4, 4'd3);
    sample_req = 1'b1;
    apply_stimulus(1'b0);
    sample_req = 1'b0;
    check_output("pre_rst_overrun", int'(overrun), 1);
    #2 rstb = 1'b0;
    #1;
    check_output("mid_rst_valid", int'(dout_valid), 0);
    check_output("mid_rst_bin", int'(bin_out), 0);
    check_output("mid_rst_delta", int'(delta_out), 0);
    check_output("mid_rst_overrun", int'(overrun), 0);
    check_output("mid_rst_gray_err", int'(gray_err), 0);
    set_bin(4'd0);
    apply_stimulus(1'b0);
    rstb = 1'b1;
    model_last = 4'd0;
    walk_to_gray(4'b0010);
    do_capture("post_rst", 4'd3, 4'd3);
    release_result("post_rst");

    // Randomized traffic against a history-based capture model
    pending = 1'b0;
    exp_bin = '0;
    for (int t = 0; t < 40; t++) begin
      if (!pending) begin
        for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
          apply_stimulus(1'($urandom_range(0, 1)));
        end
        apply_stimulus(1'($urandom_range(0, 1)));
        sample_req = 1'b1;
        exp_bin = hist[hist.size() - 1 - TS];
        apply_stimulus(1'($urandom_range(0, 1)));
        sample_req = 1'b0;
      end
      apply_stimulus(1'($urandom_range(0, 1)));
      exp_delta = exp_bin - model_last;
      model_last = exp_bin;
      check_output("rnd_valid", int'(dout_valid), 1);
      check_output("rnd_bin", int'(bin_out), int'(exp_bin));
      check_output("rnd_delta", int'(delta_out), int'(exp_delta));
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        apply_stimulus(1'($urandom_range(0, 1)));
        check_output("rnd_hold_valid", int'(dout_valid), 1);
        check_output("rnd_hold_bin", int'(bin_out), int'(exp_bin));
        check_output("rnd_hold_delta", int'(delta_out), int'(exp_delta));
      end
      b2b = (t < 39) && ($urandom_range(0, 1) == 1);
      dout_ready = 1'b1;
      sample_req = b2b;
      if (b2b) exp_bin = hist[hist.size() - 1 - TS];
      apply_stimulus(1'($urandom_range(0, 1)));
      dout_ready = 1'b0;
      sample_req = 1'b0;
      check_output("rnd_valid_drop", int'(dout_valid), 0);
      pending = b2b;
    end
    check_output("rnd_gray_err", int'(gray_err), 0);
    check_output("rnd_overrun", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gray_count_reader.md
Name: gray_count_reader

Overview:
Reader end of the Gray counter tree. It synchronizes the free-running W-bit Gray count into the clk_master domain and captures it on request. Each capture is converted to binary, and the delta since the previous capture is computed modulo 2^W. Results go to the downstream readout logic through a valid/ready handshake. It also flags illegal Gray transitions (more than one bit changing per cycle) and dropped requests.

Parameters:
W, 8, width of the Gray count and of all binary outputs (>=2)
SYNC_STAGES, 2, flops in the input synchronizer chain (>=2)

Ports:
clk_master  input  1  single clock, rising edge
rstb  input  1  asynchronous active-low reset
gray_in  input  W  reflected-Gray count from the counter tree; asynchronous to clk_master
sample_req  input  1  one-cycle capture request
dout_ready  input  1  consumer accepts the presented result
err_clr  input  1  clears the sticky error flags
bin_out  output  W  binary value of the captured count
delta_out  output  W  (bin_out - previous bin_out) mod 2^W
dout_valid  output  1  bin_out/delta_out are valid
gray_err  output  1  sticky: illegal multi-bit Gray step seen
overrun  output  1  sticky: sample_req dropped

Behaviour:
- Reset (rstb=0, async): all sync flops, prev_sync, cap_gray, last_bin, bin_out, delta_out = 0; dout_valid = 0; gray_err = 0; overrun = 0; state = IDLE.
- Synchronizer: gray_in passes through SYNC_STAGES flops to give sync_g. prev_sync <= sync_g every cycle.
- Gray check: every cycle, if popcount(sync_g ^ prev_sync) > 1, set gray_err. Zero or one bit changing is legal.
- Conversion: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i]. Purely combinational between cap_gray and the CONV register stage.
- FSM states: IDLE, CONV, PRESENT.
  - IDLE: sample_req=1 -> cap_gray <= sync_g; go to CONV.
  - CONV: bin_out <= gray2bin(cap_gray); delta_out <= gray2bin(cap_gray) - last_bin (W-bit wrap); last_bin <= gray2bin(cap_gray); dout_valid <= 1; go to PRESENT. This state always lasts exactly 1 cycle.
  - PRESENT: dout_valid is held, and bin_out/delta_out are stable until dout_ready=1.
    - dout_ready=1 and sample_req=0 -> dout_valid <= 0; go to IDLE.
    - dout_ready=1 and sample_req=1 -> dout_valid <= 0; capture sync_g; go to CONV (back-to-back, so one result per 2 cycles maximum).
- Latency: sample_req sampled at edge k -> dout_valid high after edge k+1. From gray_in to capture, add SYNC_STAGES cycles.
- Overrun is set when sample_req=1 in CONV, or in PRESENT with dout_ready=0. The request is dropped and the FSM is not disturbed.
- Sticky flags: err_clr=1 clears gray_err and overrun at the next edge. If a set condition occurs in the same cycle, set wins.
- First capture after reset: last_bin=0, so delta_out equals bin_out.
- Wrap: W=4, last_bin=14, new=2 -> delta_out=4. Equal consecutive captures -> delta_out=0.
- Reset mid-operation: asynchronous return to the reset values. Any pending result is lost and no partial handshake completes.

Decomposition:
- Shared package gray_pkg holds:
  - the state enum (IDLE, CONV, PRESENT);
  - function gray2bin(W);
  - function popcount-greater-than-one, or an equivalent onehot0 check.
- One sub-module is natural: gray_sync, a SYNC_STAGES-deep W-bit flop chain with async rstb, reusable by other counter readers.

Test Plan:
1. Reset with gray_in=0000 (W=4), then hold gray_in=0111 (5) for 3 cycles and pulse sample_req -> dout_valid 2 cycles later; bin_out=5, delta_out=5; flags 0.
2. Hold dout_ready=0 for 5 cycles after case 1 -> dout_valid and bin_out/delta_out stay at 5/5; raise dout_ready -> dout_valid drops next edge.
3. Step gray_in Gray-legally 14 (1001) -> 15 (1000) -> 0 (0000) -> 1 (0001) -> 2 (0011), capturing at 14 and then at 2 -> bin_out=2, delta_out=4 (wrap); gray_err stays 0.
4. Jump gray_in 0000 -> 0011 in one cycle -> gray_err=1 SYNC_STAGES+1 cycles later; pulse err_clr with no new violation -> gray_err=0.
5. sample_req during CONV, and during PRESENT with dout_ready=0 -> overrun=1, no extra dout_valid. Then sample_req together with dout_ready in PRESENT -> new result with no IDLE cycle.
6. Deassert rstb while in PRESENT -> dout_valid, bin_out, delta_out and flags are 0 immediately. After release, the next capture of 3 (0010) gives delta_out=3.
